// File: rtl/i2s_tx.sv
// I2S transmitter: latches one 16-bit PCM sample per frame and sends it on both L and R; BCLK/LRCK are derived from clk.
// Latency: MSB appears 2*BCLK_DIV clks after frame start; no backpressure, sample_taken is the producer's request.
`timescale 1ns/1ps
module i2s_tx #(
   parameter int BCLK_DIV  = 16,
   parameter int SLOT_BITS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pcm_in,
   input  logic        pcm_valid,
   output logic        sample_taken,
   output logic        underrun,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_sdata
);

   localparam int DW         = $clog2(BCLK_DIV);
   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_nxt;
   logic [BW-1:0] pos;
   logic [15:0]   hold_reg;
   logic [15:0]   frame_reg;
   logic          fresh;
   logic          tick;
   logic          fall;
   logic          frame_start;
   logic          lrck_nxt;
   logic          sdata_nxt;

   always_comb begin
      tick        = (div_cnt == DIV_LAST);
      fall        = tick && i2s_bclk;
      bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      lrck_nxt    = (bit_nxt >= SLOT);
      pos         = lrck_nxt ? bit_nxt - SLOT : bit_nxt;
      frame_start = fall && (bit_nxt == '0);
      // Slot position 0 is the I2S one-bit delay; bits 1..16 carry the sample MSB first.
      sdata_nxt   = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (pos == BW'(i)) sdata_nxt = frame_reg[16-i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt      <= '0;
         bit_cnt      <= BIT_LAST;
         hold_reg     <= '0;
         frame_reg    <= '0;
         fresh        <= 1'b0;
         sample_taken <= 1'b0;
         underrun     <= 1'b0;
         i2s_bclk     <= 1'b0;
         i2s_lrck     <= 1'b0;
         i2s_sdata    <= 1'b0;
      end else begin
         sample_taken <= 1'b0;
         underrun     <= 1'b0;
         div_cnt      <= tick ? '0 : div_cnt + 1'b1;
         if (tick) i2s_bclk <= ~i2s_bclk;
         if (fall) begin
            bit_cnt   <= bit_nxt;
            i2s_lrck  <= lrck_nxt;
            i2s_sdata <= sdata_nxt;
         end
         if (frame_start) begin
            frame_reg    <= hold_reg;
            sample_taken <= 1'b1;
            underrun     <= ~fresh;
            fresh        <= 1'b0;
         end
         // A new sample on the frame-start edge wins over the clear and goes out next frame.
         if (pcm_valid) begin
            hold_reg <= pcm_in;
            fresh    <= 1'b1;
         end
      end
   end

endmodule
